// File: rtl/packet_bank_tx_if.sv
// Bus bundle for packet_bank_tx: start/abort command inputs, SRAM read port
// and the framed serial output. The master modport is the transmitter's view;
// the slave modport is the host/SRAM/receiver view of the same wires.
interface packet_bank_tx_if #(
    parameter int BW_MEM   = 16,
    parameter int MAX_LINE = 256,
    parameter int ADDR_W   = $clog2(MAX_LINE)
) ();
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic              abort;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [BW_MEM-1:0] mem_data_in;
    logic              data_out;
    logic              sos;
    logic              eos;
    logic              busy;
    logic              done;

    modport master (
        input  start, num_words, abort, mem_data_in,
        output mem_rd_en, mem_addr, data_out, sos, eos, busy, done
    );

    modport slave (
        output start, num_words, abort, mem_data_in,
        input  mem_rd_en, mem_addr, data_out, sos, eos, busy, done
    );
endinterface

// File: rtl/packet_bank_tx.sv
// packet_bank_tx: serial transmitter for the packet-bank link.
// Reads up to MAX_LINE words from an SRAM with 1-cycle read latency and sends
// them MSB-first on a single wire, framed by a one-cycle sos before the first
// bit and a one-cycle eos after the last bit. Words go out back-to-back: the
// next word is prefetched two bit-times before the end of the current one.
// Optional build macro PACKET_BANK_TX_PARITY_EN appends one even-parity bit
// after every word (S = BW_MEM+1 bit-times per word instead of BW_MEM).
// All outputs are decoded from registers only.
module packet_bank_tx #(
    parameter int BW_MEM   = 16,
    parameter int MAX_LINE = 256,
    parameter int ADDR_W   = $clog2(MAX_LINE)
) (
    input  logic               clk,
    input  logic               reset,
    packet_bank_tx_if.master   bus
);

`ifdef PACKET_BANK_TX_PARITY_EN
    localparam int S = BW_MEM + 1;
`else
    localparam int S = BW_MEM;
`endif
    // Bit index must reach S-1 in either build.
    localparam int IDX_W = $clog2(BW_MEM + 2);
    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(MAX_LINE);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(S - 1);
    localparam logic [IDX_W-1:0] IDX_PREFETCH = IDX_W'(S - 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SOS   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_EOS   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t             state_reg;
    logic [ADDR_W:0]    words_left_reg;   // words not yet read from SRAM
    logic [ADDR_W-1:0]  addr_reg;         // address of the next SRAM read
    logic [BW_MEM-1:0]  shift_reg;
    logic [BW_MEM-1:0]  hold_reg;
    logic               rd_pending_reg;   // a read was issued last cycle
    logic               next_valid_reg;   // a prefetched word follows this one
    logic [IDX_W-1:0]   bit_idx_reg;
    logic               aborted_reg;
`ifdef PACKET_BANK_TX_PARITY_EN
    logic               parity_reg;       // even parity of the word in shift_reg
`endif

    logic               rd_now;
    logic [BW_MEM-1:0]  hold_next;
    logic               data_bit;
    logic [ADDR_W:0]    start_words;

    // A read is issued in FETCH, and in SHIFT two bit-times before the end of
    // a word when more words remain.
    always_comb begin
        rd_now = 1'b0;
        if (state_reg == ST_FETCH) begin
            rd_now = 1'b1;
        end else if (state_reg == ST_SHIFT && bit_idx_reg == IDX_PREFETCH &&
                     words_left_reg != '0) begin
            rd_now = 1'b1;
        end
    end

    // Read data lands in the hold register the cycle after a read; bypass it so
    // the reload at the last bit-time sees the word arriving this cycle.
    assign hold_next   = rd_pending_reg ? bus.mem_data_in : hold_reg;

    // Clamp the requested frame length to the SRAM depth.
    assign start_words = (bus.num_words > MAX_WORDS) ? MAX_WORDS : bus.num_words;

    // Serial data: shift register MSB while shifting (parity bit in its slot).
    always_comb begin
        data_bit = 1'b0;
        if (state_reg == ST_SHIFT) begin
`ifdef PACKET_BANK_TX_PARITY_EN
            if (bit_idx_reg == IDX_LAST) begin
                data_bit = parity_reg;
            end else begin
                data_bit = shift_reg[BW_MEM-1];
            end
`else
            data_bit = shift_reg[BW_MEM-1];
`endif
        end
    end

    assign bus.mem_rd_en = rd_now;
    assign bus.mem_addr  = rd_now ? addr_reg : '0;
    assign bus.data_out  = data_bit;
    assign bus.sos       = (state_reg == ST_SOS);
    assign bus.eos       = (state_reg == ST_EOS);
    assign bus.busy      = (state_reg == ST_FETCH) || (state_reg == ST_SOS) ||
                           (state_reg == ST_SHIFT) || (state_reg == ST_EOS);
    assign bus.done      = (state_reg == ST_DONE);

    // Frame sequencer together with the fetch/shift datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            words_left_reg <= '0;
            addr_reg       <= '0;
            shift_reg      <= '0;
            hold_reg       <= '0;
            rd_pending_reg <= 1'b0;
            next_valid_reg <= 1'b0;
            bit_idx_reg    <= '0;
            aborted_reg    <= 1'b0;
`ifdef PACKET_BANK_TX_PARITY_EN
            parity_reg     <= 1'b0;
`endif
        end else begin
            rd_pending_reg <= rd_now;
            if (rd_pending_reg) begin
                hold_reg <= bus.mem_data_in;
            end
            if (rd_now) begin
                addr_reg       <= addr_reg + ADDR_W'(1);
                words_left_reg <= words_left_reg - (ADDR_W + 1)'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    if (bus.start && bus.num_words != '0) begin
                        words_left_reg <= start_words;
                        addr_reg       <= '0;
                        next_valid_reg <= 1'b0;
                        aborted_reg    <= 1'b0;
                        state_reg      <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (bus.abort) begin
                        aborted_reg <= 1'b1;
                        state_reg   <= ST_EOS;
                    end else begin
                        state_reg   <= ST_SOS;
                    end
                end

                ST_SOS: begin
                    if (bus.abort) begin
                        aborted_reg <= 1'b1;
                        state_reg   <= ST_EOS;
                    end else begin
                        shift_reg   <= bus.mem_data_in;
`ifdef PACKET_BANK_TX_PARITY_EN
                        parity_reg  <= ^bus.mem_data_in;
`endif
                        bit_idx_reg <= '0;
                        state_reg   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (bus.abort) begin
                        aborted_reg <= 1'b1;
                        state_reg   <= ST_EOS;
                    end else if (bit_idx_reg == IDX_LAST) begin
                        if (next_valid_reg) begin
                            shift_reg      <= hold_next;
`ifdef PACKET_BANK_TX_PARITY_EN
                            parity_reg     <= ^hold_next;
`endif
                            bit_idx_reg    <= '0;
                            next_valid_reg <= 1'b0;
                        end else begin
                            state_reg      <= ST_EOS;
                        end
                    end else begin
                        shift_reg   <= {shift_reg[BW_MEM-2:0], 1'b0};
                        bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        if (rd_now) begin
                            next_valid_reg <= 1'b1;
                        end
                    end
                end

                ST_EOS: begin
                    state_reg <= aborted_reg ? ST_IDLE : ST_DONE;
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/packet_bank_tx.md
Name: packet_bank_tx

Overview:
Serial transmitter for the packet-bank link: the sending end of the sos/eos framed one-bit stream. On a start command it reads packet lines from a local SRAM with 1-cycle read latency and serializes each BW_MEM-bit word MSB-first onto a single data wire. It frames the burst with an sos pulse before the first bit and an eos pulse after the last bit. It sits on the host/loader side and feeds the receiving packet controller during its Prepare phase.

Parameters:
BW_MEM, 16, width of one packet line word; must be >= 4
MAX_LINE, 256, maximum lines per frame; equals SRAM depth
ADDR_W, $clog2(MAX_LINE), SRAM address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to send a frame; sampled only in IDLE
num_words  in  ADDR_W+1  lines to send; 0 = ignore start; values > MAX_LINE are clamped to MAX_LINE
abort  in  1  terminate the current frame early
mem_rd_en  out  1  SRAM read strobe; data returns on mem_data_in the next cycle
mem_addr  out  ADDR_W  SRAM read address
mem_data_in  in  BW_MEM  SRAM read data
data_out  out  1  serial data, MSB first
sos  out  1  start-of-stream pulse
eos  out  1  end-of-stream pulse
busy  out  1  frame in progress
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset value of every output and register is 0; state returns to IDLE. Reset is asynchronous, so it takes effect mid-frame with no eos.
- State register is one-hot or binary. mem_rd_en, mem_addr, sos, eos, busy, done and data_out decode combinationally from registers only; none depends combinationally on any input.
- IDLE: if start=1 and num_words!=0, latch min(num_words, MAX_LINE) into the word counter, clear the address, and go to FETCH. Otherwise stay in IDLE. data_out=0.
- FETCH (1 cycle): mem_rd_en=1, mem_addr=0, busy=1. Next state is SOS.
- SOS (1 cycle): sos=1, busy=1, data_out=0. Load mem_data_in into the shift register. Next state is SHIFT with bit index 0.
- SHIFT: data_out = shift register MSB. Shift left each cycle and increment the bit index 0..S-1, where S = BW_MEM in the base build.
  - At index S-2, if words remain: mem_rd_en=1, mem_addr = next address.
  - The cycle after that read, mem_data_in is always captured into a one-entry hold register.
  - At index S-1, if words remain, load the shift register from the hold register. Words are sent back-to-back with no gap bits.
  - After the last bit of the last word, go to EOS.
- EOS (1 cycle): eos=1, busy=1, data_out=0. Next state is DONE on normal completion, IDLE after an abort.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE.
- Timing for N words, start sampled in cycle 0:
  - sos in cycle 2
  - bits in cycles 3 .. 2+N*S
  - eos in cycle 3+N*S
  - done in cycle 4+N*S
- Addresses increment by 1 from 0 to N-1 and never wrap. With N=MAX_LINE the last address is MAX_LINE-1.
- abort=1 in FETCH, SOS or SHIFT: the next state is EOS, no further reads are issued, and done is not pulsed. abort in IDLE, EOS or DONE is ignored. abort has priority over normal SHIFT progression in the same cycle.
- start while busy or in DONE is ignored and is not queued.

Optional Feature:
Macro PACKET_BANK_TX_PARITY_EN.
- Defined: each word is followed by one even-parity bit (XOR of its BW_MEM bits), so S = BW_MEM+1.
  - The prefetch read moves to index S-2.
  - The shift register is reloaded at index S-1, the parity-bit cycle.
  - Frame timing uses S = BW_MEM+1.
- Undefined: no parity bit; S = BW_MEM.

Test Plan:
1. N=1, word 0xA5C3: start in cycle 0 -> mem_rd_en with addr 0 in cycle 1; sos in cycle 2; data_out over cycles 3..18 = 1010010111000011; eos in cycle 19; done in cycle 20; busy=1 over cycles 1..19.
2. N=3, words 0x0001, 0x8000, 0xFFFF -> reads at addr 0, 1, 2; 48 contiguous bits with no gap; eos in cycle 51; exactly 3 mem_rd_en pulses.
3. num_words=300 -> clamped to 256; last mem_addr=255; eos in cycle 3+256*16=4099. num_words=0 with start -> remains IDLE, all outputs 0.
4. abort in the 5th bit cycle of word 1 of N=4 -> eos on the next cycle; no done; IDLE after; no mem_rd_en after the abort; a new start is then accepted normally.
5. reset asserted mid-SHIFT -> all outputs 0 immediately, no eos; start after release sends a full frame correctly. start pulsed while busy -> ignored.
6. With PACKET_BANK_TX_PARITY_EN, N=2, words 0x0003 and 0x0001 -> 17 bits per word; parity bits 0 and 1; eos in cycle 3+34=37.
